// File: rtl/seq_play_if.sv
// seq_play_if: control/status bundle between a game controller and seq_play.
//   master (controller): drives setup, start, next, tick, rd_idx;
//                        observes rd_color, led, len, busy, done, full.
//   slave  (seq_play):   the reverse directions.
//   MAX_LEN must match the seq_play instance it connects to.
interface seq_play_if #(
  parameter int unsigned MAX_LEN = 16
);
  localparam int unsigned LW = $clog2(MAX_LEN);

  logic [7:0]    setup;
  logic          start;
  logic          next;
  logic          tick;
  logic [LW-1:0] rd_idx;
  logic [1:0]    rd_color;
  logic [3:0]    led;
  logic [LW:0]   len;
  logic          busy;
  logic          done;
  logic          full;

  modport master (
    output setup, start, next, tick, rd_idx,
    input  rd_color, led, len, busy, done, full
  );

  modport slave (
    input  setup, start, next, tick, rd_idx,
    output rd_color, led, len, busy, done, full
  );
endinterface

// File: rtl/seq_play.sv
// seq_play: colour-sequence generator and player for a memory game.
//   A start pulse seeds an 8-bit LFSR and builds a one-colour sequence; each
//   next pulse appends one colour. After every append the whole sequence is
//   replayed on led (one-hot), each colour held for (4 - setup[1:0]) tick
//   pulses and followed by a one-tick dark gap; done pulses at the end.
// Ports:
//   clk   - clock, rising edge
//   R     - asynchronous active-low reset
//   bus   - seq_play_if.slave: setup/start/next/tick/rd_idx in,
//           rd_color (combinational)/led/len/busy/done/full out
// Build option: define SEQ_PLAY_NOREPEAT_EN to bump a generated colour by one
//   (mod 4) whenever it would equal the previously stored colour.
module seq_play #(
  parameter int unsigned MAX_LEN = 16
) (
  input logic        clk,
  input logic        R,
  seq_play_if.slave  bus
);

  localparam int unsigned LW = $clog2(MAX_LEN);
  localparam int unsigned CW = LW + 1;

  typedef enum logic [2:0] {IDLE, GEN, SHOW, GAP, FIN} state_t;

  state_t        state, state_n;
  logic [7:0]    lfsr, lfsr_n;
  logic [CW-1:0] len_q, len_n;
  logic [LW-1:0] idx, idx_n;
  logic [1:0]    tcnt, tcnt_n;

  logic [3:0]    led_q, led_n;
  logic          done_q, done_n;
  logic          busy_q, busy_n;
  logic          full_q, full_n;

  logic [1:0]    mem [MAX_LEN];
  logic          wr_en;
  logic [LW-1:0] wr_addr;
  logic [1:0]    wr_color;

  logic [7:0]    seed;
  logic [7:0]    lfsr_shift;
  logic [1:0]    gen_color;
  logic [2:0]    show_ticks;
  logic [2:0]    tcnt_inc;
  logic [CW-1:0] idx_inc;
  logic [1:0]    show_color;

  // Helpers shared by the FSM
  assign seed       = (bus.setup == 8'h00) ? 8'hA5 : bus.setup;
  assign lfsr_shift = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign show_ticks = 3'd4 - {1'b0, bus.setup[1:0]};
  assign tcnt_inc   = {1'b0, tcnt} + 3'd1;
  assign idx_inc    = {1'b0, idx} + CW'(1);

`ifdef SEQ_PLAY_NOREPEAT_EN
  logic [1:0] prev_color;
  // len_q - 1 wraps when len_q is 0, but that case is masked below
  assign prev_color = mem[LW'(len_q - CW'(1))];
  assign gen_color  = ((len_q != '0) && (lfsr_shift[1:0] == prev_color))
                      ? lfsr_shift[1:0] + 2'd1 : lfsr_shift[1:0];
`else
  assign gen_color  = lfsr_shift[1:0];
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state  <= IDLE;
      lfsr   <= 8'hA5;
      len_q  <= '0;
      idx    <= '0;
      tcnt   <= '0;
      led_q  <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      full_q <= 1'b0;
    end else begin
      state  <= state_n;
      lfsr   <= lfsr_n;
      len_q  <= len_n;
      idx    <= idx_n;
      tcnt   <= tcnt_n;
      led_q  <= led_n;
      done_q <= done_n;
      busy_q <= busy_n;
      full_q <= full_n;
    end
  end

  // Sequence storage; len masks stale contents so no reset is needed
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_color;
    end
  end

  // Next-state logic
  always_comb begin
    state_n  = state;
    lfsr_n   = lfsr;
    len_n    = len_q;
    idx_n    = idx;
    tcnt_n   = tcnt;
    wr_en    = 1'b0;
    wr_addr  = len_q[LW-1:0];
    wr_color = gen_color;

    case (state)
      IDLE: begin
        if (bus.start) begin
          lfsr_n  = seed;
          len_n   = '0;
          state_n = GEN;
        end else if (bus.next && (len_q != CW'(MAX_LEN)) && (len_q != '0)) begin
          state_n = GEN;
        end
      end

      GEN: begin
        lfsr_n  = lfsr_shift;
        wr_en   = 1'b1;
        len_n   = len_q + CW'(1);
        idx_n   = '0;
        tcnt_n  = '0;
        state_n = SHOW;
      end

      SHOW: begin
        if (bus.start) begin
          lfsr_n  = seed;
          len_n   = '0;
          idx_n   = '0;
          tcnt_n  = '0;
          state_n = GEN;
        end else if (bus.tick) begin
          // >= keeps playback moving if setup shortens the hold mid-colour
          if (tcnt_inc >= show_ticks) begin
            tcnt_n  = '0;
            state_n = GAP;
          end else begin
            tcnt_n  = tcnt_inc[1:0];
          end
        end
      end

      GAP: begin
        if (bus.start) begin
          lfsr_n  = seed;
          len_n   = '0;
          idx_n   = '0;
          tcnt_n  = '0;
          state_n = GEN;
        end else if (bus.tick) begin
          if (idx_inc < len_q) begin
            idx_n   = idx_inc[LW-1:0];
            state_n = SHOW;
          end else begin
            state_n = FIN;
          end
        end
      end

      FIN: begin
        if (bus.start) begin
          lfsr_n  = seed;
          len_n   = '0;
          idx_n   = '0;
          tcnt_n  = '0;
          state_n = GEN;
        end else begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Registered outputs computed from the next state; the colour being
  // written this cycle is forwarded so the first SHOW sees it
  always_comb begin
    show_color = mem[idx_n];
    if (wr_en && (wr_addr == idx_n)) begin
      show_color = wr_color;
    end
    led_n  = (state_n == SHOW) ? (4'(1) << show_color) : 4'b0000;
    done_n = (state_n == FIN);
    busy_n = (state_n != IDLE);
    full_n = (len_n == CW'(MAX_LEN));
  end

  assign bus.led      = led_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.full     = full_q;
  assign bus.len      = len_q;
  assign bus.rd_color = ({1'b0, bus.rd_idx} < len_q) ? mem[bus.rd_idx] : 2'b00;

endmodule

// File: doc/seq_play.md
SEQ_PLAY -- requirements
Module: seq_play

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: maximum sequence length, power of two, 2..32.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port R  input  1  reset, asynchronous and active-low (0 = reset).
REQ-004 SHALL have port setup  input  8  configuration word from the setup register; whole word is the LFSR seed, setup[1:0] is the speed.
REQ-005 SHALL have port start  input  1  one-cycle pulse: begin a new game.
REQ-006 SHALL have port next  input  1  one-cycle pulse: append one color and replay.
REQ-007 SHALL have port tick  input  1  one-cycle timebase enable.
REQ-008 SHALL have port rd_idx  input  log2(MAX_LEN)  read index for the external matcher.
REQ-009 SHALL have port rd_color  output  2  stored color at rd_idx; combinational read.
REQ-010 SHALL have port led  output  4  one-hot color being shown, else 4'b0000.
REQ-011 SHALL have port len  output  log2(MAX_LEN)+1  current sequence length.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse at the end of playback.
REQ-014 SHALL have port full  output  1  high while len == MAX_LEN.

Function
REQ-015 SHALL implement FSM states IDLE, GEN, SHOW, GAP and FIN.
REQ-016 In IDLE, start SHALL load the LFSR with setup, or with 8'hA5 if setup == 0, clear len, and go to GEN.
REQ-017 In IDLE, next with full == 0 and len > 0 SHALL go to GEN; otherwise next SHALL be ignored.
REQ-018 start and next in the same cycle SHALL be treated as start.
REQ-019 In SHOW, GAP or FIN, start SHALL abort playback and behave as in REQ-016; next SHALL be ignored.
REQ-020 The LFSR SHALL be 8 bits, Fibonacci, taps x^8+x^6+x^5+x^4+1, shifted once per GEN cycle.
REQ-021 GEN SHALL last one cycle, write color = post-shift LFSR[1:0] to mem[len], increment len, clear the play index, and go to SHOW.
REQ-022 In SHOW, led SHALL equal one-hot(mem[index]), with color 0 on bit 0 and color 3 on bit 3.
REQ-023 SHOW SHALL last (4 - setup[1:0]) tick pulses; setup SHALL be sampled live.
REQ-024 GAP SHALL hold led = 0 for exactly one tick pulse.
REQ-025 After GAP, the FSM SHALL increment the index and return to SHOW if index+1 < len, else go to FIN.
REQ-026 FIN SHALL assert done for one cycle and return to IDLE.
REQ-027 tick SHALL be ignored in IDLE, GEN and FIN.
REQ-028 led SHALL be 4'b0000 in every state except SHOW.
REQ-029 rd_color SHALL be undefined-safe (return 2'b00) for rd_idx >= len.

Reset
REQ-030 R low SHALL immediately force state IDLE, led 0, len 0, done 0, busy 0, full 0, LFSR 8'hA5, tick counter 0 and index 0.
REQ-031 Reset asserted mid-playback SHALL extinguish led without waiting for a clock edge.
REQ-032 Memory contents need not be cleared by reset; len 0 masks them per REQ-029.

Configuration
REQ-033 With SEQ_PLAY_NOREPEAT_EN defined, GEN SHALL store (color+1) mod 4 when color equals mem[len-1] and len > 0.
REQ-034 Without SEQ_PLAY_NOREPEAT_EN, adjacent equal colors SHALL be stored unmodified.

Verification
REQ-035 setup=8'h03, start, tick every cycle -> len=1, led one-hot for 1 cycle, led 0 for 1 cycle, done pulse, busy falls.
REQ-036 setup=8'h00, start, tick every 4th cycle -> LFSR seeded 8'hA5, led on for 4 ticks (16 cycles), len=1.
REQ-037 start then 15 next after each done -> len=16, full=1, 16 colors replayed; 17th next -> ignored, len stays 16.
REQ-038 start and next in the same cycle from IDLE with len=5 -> len=1 (restart); R low during SHOW -> led=0, len=0 asynchronously.
REQ-039 With SEQ_PLAY_NOREPEAT_EN defined, 16-entry game over seeds 8'h01..8'hFF -> no rd_color[i]==rd_color[i+1]; undefined -> matches reference LFSR model.
